// File: rtl/result_collector_pkg.sv
// Shared score-bank constants and small helpers for the result collector slice.
package result_collector_pkg;

    localparam int SCORE_WIDTH_DEF = 12;
    localparam int ID_WIDTH_DEF    = 48;

    // Biased score encoding: this value represents a raw score of zero.
    localparam logic [SCORE_WIDTH_DEF-1:0] ZERO = SCORE_WIDTH_DEF'(2 ** (SCORE_WIDTH_DEF - 1));

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/result_collector_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping through N channels.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int CH_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            any
);

    int idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Collects per-channel result strobes into holding slots, serializes them round-robin
// onto a valid/ready output, and tracks the running maximum score per query.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int SCORE_WIDTH = SCORE_WIDTH_DEF,
    parameter int ID_WIDTH    = ID_WIDTH_DEF,
    parameter int CHANNELS    = 4,
    parameter int CH_W        = ch_width(CHANNELS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS-1:0]             vld_in,
    input  logic [CHANNELS*SCORE_WIDTH-1:0] res_in,
    input  logic [CHANNELS*ID_WIDTH-1:0]    id_in,
    input  logic                            clr_max,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [SCORE_WIDTH-1:0]          out_score,
    output logic [ID_WIDTH-1:0]             out_id,
    output logic [CH_W-1:0]                 out_ch,
    output logic [SCORE_WIDTH-1:0]          max_score,
    output logic [ID_WIDTH-1:0]             max_id,
    output logic                            max_valid,
    output logic [CHANNELS-1:0]             overflow,
    output logic                            busy
);

    logic [CHANNELS-1:0]    slot_full;
    logic [SCORE_WIDTH-1:0] slot_score [CHANNELS];
    logic [ID_WIDTH-1:0]    slot_id    [CHANNELS];
    logic [CH_W-1:0]        rr_ptr;

    logic [CHANNELS-1:0]    grant;
    logic [CH_W-1:0]        grant_idx;
    logic                   grant_any;

    rr_arbiter #(
        .N    (CHANNELS),
        .CH_W (CH_W)
    ) u_arb (
        .req       (slot_full),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    logic                advance;
    logic [CHANNELS-1:0] take_mask;
    logic [CHANNELS-1:0] slot_load;
    logic [CHANNELS-1:0] slot_drop;
    logic [CH_W-1:0]     ptr_next;

    assign advance   = !out_valid || out_ready;
    assign take_mask = (advance && grant_any) ? grant : '0;
    // A slot being drained this cycle can accept a new strobe at the same edge.
    assign slot_load = vld_in & (~slot_full | take_mask);
    assign slot_drop = vld_in & slot_full & ~take_mask;
    assign ptr_next  = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
    assign busy      = (|slot_full) | out_valid;

    logic                   cand_valid;
    logic [SCORE_WIDTH-1:0] cand_score;
    logic [ID_WIDTH-1:0]    cand_id;

    // Strictly-greater scan keeps the lowest channel on ties.
    always_comb begin
        cand_valid = 1'b0;
        cand_score = '0;
        cand_id    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (vld_in[c] && (!cand_valid || res_in[c*SCORE_WIDTH +: SCORE_WIDTH] > cand_score)) begin
                cand_valid = 1'b1;
                cand_score = res_in[c*SCORE_WIDTH +: SCORE_WIDTH];
                cand_id    = id_in[c*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    logic base_max_valid;
    assign base_max_valid = max_valid && !clr_max;

    // NOTE: slot payload is not reset; the full bits alone decide whether it is meaningful.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (slot_load[c]) begin
                slot_score[c] <= res_in[c*SCORE_WIDTH +: SCORE_WIDTH];
                slot_id[c]    <= id_in[c*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    // NOTE: non-blocking assignments let the output read the slot's pre-edge contents
    // while the same slot reloads from a simultaneous strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            overflow  <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_score <= '0;
            out_id    <= '0;
            out_ch    <= '0;
            max_valid <= 1'b0;
            max_score <= '0;
            max_id    <= '0;
        end else begin
            slot_full <= (slot_full & ~take_mask) | slot_load;
            overflow  <= overflow | slot_drop;

            if (advance) begin
                if (grant_any) begin
                    out_valid <= 1'b1;
                    out_score <= slot_score[grant_idx];
                    out_id    <= slot_id[grant_idx];
                    out_ch    <= grant_idx;
                    rr_ptr    <= ptr_next;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            if (cand_valid && (!base_max_valid || cand_score > max_score)) begin
                max_score <= cand_score;
                max_id    <= cand_id;
            end
            max_valid <= base_max_valid || cand_valid;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench: directed table, multi-cycle corner sequences, and randomized
// traffic compared against a behavioural model of the collector.
module tb_result_collector;

    localparam int SW = 12;
    localparam int IW = 48;
    localparam int NC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     vld_in;
    logic [NC*SW-1:0]  res_in;
    logic [NC*IW-1:0]  id_in;
    logic              clr_max;
    logic              out_ready;
    logic              out_valid;
    logic [SW-1:0]     out_score;
    logic [IW-1:0]     out_id;
    logic [1:0]        out_ch;
    logic [SW-1:0]     max_score;
    logic [IW-1:0]     max_id;
    logic              max_valid;
    logic [NC-1:0]     overflow;
    logic              busy;

    always #5 clk = ~clk;

    result_collector dut (
        .clk       (clk),
        .rst       (rst),
        .vld_in    (vld_in),
        .res_in    (res_in),
        .id_in     (id_in),
        .clr_max   (clr_max),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_score (out_score),
        .out_id    (out_id),
        .out_ch    (out_ch),
        .max_score (max_score),
        .max_id    (max_id),
        .max_valid (max_valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*SW-1:0] res4(input logic [SW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [NC*IW-1:0] ids4(input logic [IW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic drive(input logic r, input logic [NC-1:0] v, input logic [NC*SW-1:0] rs,
                         input logic [NC*IW-1:0] ids, input logic clr, input logic rdy);
        rst = r; vld_in = v; res_in = rs; id_in = ids; clr_max = clr; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic          m_full  [NC];
    logic [SW-1:0] m_score [NC];
    logic [IW-1:0] m_id    [NC];
    logic [NC-1:0] m_ovf;
    int            m_ptr;
    logic          m_out_v;
    logic [SW-1:0] m_out_s;
    logic [IW-1:0] m_out_id;
    int            m_out_ch;
    logic          m_max_v;
    logic [SW-1:0] m_max_s;
    logic [IW-1:0] m_max_id;

    task automatic model_step();
        int g;
        int best;
        if (rst) begin
            for (int c = 0; c < NC; c++) m_full[c] = 1'b0;
            m_ovf = '0; m_ptr = 0; m_out_v = 1'b0; m_out_s = '0; m_out_id = '0;
            m_out_ch = 0; m_max_v = 1'b0; m_max_s = '0; m_max_id = '0;
            return;
        end
        g = -1;
        if (!m_out_v || out_ready) begin
            for (int k = 0; k < NC; k++)
                if (g < 0 && m_full[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
            if (g >= 0) begin
                m_out_v = 1'b1; m_out_s = m_score[g]; m_out_id = m_id[g];
                m_out_ch = g; m_ptr = (g + 1) % NC;
            end else begin
                m_out_v = 1'b0;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (vld_in[c]) begin
                if (!m_full[c] || g == c) begin
                    m_full[c] = 1'b1;
                    m_score[c] = res_in[c*SW +: SW];
                    m_id[c] = id_in[c*IW +: IW];
                end else begin
                    m_ovf[c] = 1'b1;
                end
            end else if (g == c) begin
                m_full[c] = 1'b0;
            end
        end
        best = -1;
        for (int c = 0; c < NC; c++)
            if (vld_in[c] && (best < 0 || res_in[c*SW +: SW] > res_in[best*SW +: SW])) best = c;
        if (clr_max) m_max_v = 1'b0;
        if (best >= 0) begin
            if (!m_max_v || res_in[best*SW +: SW] > m_max_s) begin
                m_max_s = res_in[best*SW +: SW];
                m_max_id = id_in[best*IW +: IW];
            end
            m_max_v = 1'b1;
        end
    endtask

    function automatic logic model_busy();
        logic b;
        b = m_out_v;
        for (int c = 0; c < NC; c++) b = b | m_full[c];
        return b;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic             rst;
        logic [NC-1:0]    vld;
        logic [NC*SW-1:0] res;
        logic [NC*IW-1:0] ids;
        logic             ready;
        logic             e_ov;
        logic [1:0]       e_ch;
        logic [SW-1:0]    e_score;
        logic [IW-1:0]    e_id;
        logic             e_max_v;
        logic [SW-1:0]    e_max;
        logic [IW-1:0]    e_max_id;
        logic [NC-1:0]    e_ovf;
        logic             e_busy;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [NC*SW-1:0] zr;
        logic [NC*IW-1:0] zi;
        logic [SW-1:0]    sc;
        zr = '0;
        zi = '0;

        // reset state
        drive(1'b1, '0, zr, zi, 1'b0, 1'b1);
        drive(1'b1, '0, zr, zi, 1'b0, 1'b1);
        check("rst out_valid", 64'(out_valid), 0);
        check("rst busy", 64'(busy), 0);
        check("rst max_valid", 64'(max_valid), 0);
        check("rst overflow", 64'(overflow), 0);
        check("rst out_score", 64'(out_score), 0);
        check("rst max_score", 64'(max_score), 0);

        tbl[0] = '{1'b0, 4'b0100, res4(0, 0, 12'h805, 0), ids4(0, 0, 7, 0), 1'b1,
                   1'b0, 2'd0, 12'h0, 48'h0, 1'b1, 12'h805, 48'h7, 4'b0, 1'b1};
        tbl[1] = '{1'b0, 4'b0000, zr, zi, 1'b1,
                   1'b1, 2'd2, 12'h805, 48'h7, 1'b1, 12'h805, 48'h7, 4'b0, 1'b1};
        tbl[2] = '{1'b0, 4'b0000, zr, zi, 1'b1,
                   1'b0, 2'd0, 12'h0, 48'h0, 1'b1, 12'h805, 48'h7, 4'b0, 1'b0};
        tbl[3] = '{1'b1, 4'b0000, zr, zi, 1'b1,
                   1'b0, 2'd0, 12'h0, 48'h0, 1'b0, 12'h0, 48'h0, 4'b0, 1'b0};
        tbl[4] = '{1'b0, 4'b1111, res4(12'h801, 12'h810, 12'h810, 12'h802),
                   ids4(48'h11, 48'h22, 48'h33, 48'h44), 1'b1,
                   1'b0, 2'd0, 12'h0, 48'h0, 1'b1, 12'h810, 48'h22, 4'b0, 1'b1};
        tbl[5] = '{1'b0, 4'b0000, zr, zi, 1'b1,
                   1'b1, 2'd0, 12'h801, 48'h11, 1'b1, 12'h810, 48'h22, 4'b0, 1'b1};
        tbl[6] = '{1'b0, 4'b0000, zr, zi, 1'b1,
                   1'b1, 2'd1, 12'h810, 48'h22, 1'b1, 12'h810, 48'h22, 4'b0, 1'b1};
        tbl[7] = '{1'b0, 4'b0000, zr, zi, 1'b1,
                   1'b1, 2'd2, 12'h810, 48'h33, 1'b1, 12'h810, 48'h22, 4'b0, 1'b1};
        tbl[8] = '{1'b0, 4'b0000, zr, zi, 1'b1,
                   1'b1, 2'd3, 12'h802, 48'h44, 1'b1, 12'h810, 48'h22, 4'b0, 1'b1};
        tbl[9] = '{1'b0, 4'b0000, zr, zi, 1'b1,
                   1'b0, 2'd0, 12'h0, 48'h0, 1'b1, 12'h810, 48'h22, 4'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].res, tbl[i].ids, 1'b0, tbl[i].ready);
            check($sformatf("tbl%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                check($sformatf("tbl%0d out_ch", i), 64'(out_ch), 64'(tbl[i].e_ch));
                check($sformatf("tbl%0d out_score", i), 64'(out_score), 64'(tbl[i].e_score));
                check($sformatf("tbl%0d out_id", i), 64'(out_id), 64'(tbl[i].e_id));
            end
            check($sformatf("tbl%0d max_valid", i), 64'(max_valid), 64'(tbl[i].e_max_v));
            if (tbl[i].e_max_v) begin
                check($sformatf("tbl%0d max_score", i), 64'(max_score), 64'(tbl[i].e_max));
                check($sformatf("tbl%0d max_id", i), 64'(max_id), 64'(tbl[i].e_max_id));
            end
            check($sformatf("tbl%0d overflow", i), 64'(overflow), 64'(tbl[i].e_ovf));
            check($sformatf("tbl%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
        end

        // Backpressure: held output, slot fill, then a dropped third strobe.
        drive(1'b1, '0, zr, zi, 1'b0, 1'b0);
        drive(1'b0, 4'b0001, res4(12'h900, 0, 0, 0), ids4(1, 0, 0, 0), 1'b0, 1'b0);
        check("bp first not out yet", 64'(out_valid), 0);
        drive(1'b0, 4'b0001, res4(12'h901, 0, 0, 0), ids4(2, 0, 0, 0), 1'b0, 1'b0);
        check("bp out_valid", 64'(out_valid), 1);
        check("bp out_score 900", 64'(out_score), 64'h900);
        drive(1'b0, 4'b0001, res4(12'h902, 0, 0, 0), ids4(3, 0, 0, 0), 1'b0, 1'b0);
        check("bp overflow0", 64'(overflow), 64'b0001);
        check("bp held score", 64'(out_score), 64'h900);
        check("bp max 902", 64'(max_score), 64'h902);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b0);
        check("bp still held", 64'(out_id), 1);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b1);
        check("bp second out", 64'(out_score), 64'h901);
        check("bp second id", 64'(out_id), 2);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b1);
        check("bp 902 never out", 64'(out_valid), 0);
        check("bp overflow sticky", 64'(overflow), 64'b0001);

        // Grant and strobe on the same channel in the same cycle.
        drive(1'b1, '0, zr, zi, 1'b0, 1'b1);
        drive(1'b0, 4'b0010, res4(0, 12'h111, 0, 0), ids4(0, 48'hA, 0, 0), 1'b0, 1'b1);
        drive(1'b0, 4'b0010, res4(0, 12'h222, 0, 0), ids4(0, 48'hB, 0, 0), 1'b0, 1'b1);
        check("same old score", 64'(out_score), 64'h111);
        check("same old ch", 64'(out_ch), 1);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b1);
        check("same new valid", 64'(out_valid), 1);
        check("same new score", 64'(out_score), 64'h222);
        check("same new id", 64'(out_id), 64'hB);
        check("same overflow", 64'(overflow), 0);

        // clr_max with a same-cycle strobe lower than the old max.
        drive(1'b0, 4'b0001, res4(12'hA00, 0, 0, 0), ids4(5, 0, 0, 0), 1'b0, 1'b1);
        check("clr pre max", 64'(max_score), 64'hA00);
        drive(1'b0, 4'b1000, res4(0, 0, 0, 12'h7F0), ids4(0, 0, 0, 9), 1'b1, 1'b1);
        check("clr+strobe max", 64'(max_score), 64'h7F0);
        check("clr+strobe max_id", 64'(max_id), 9);
        check("clr+strobe valid", 64'(max_valid), 1);
        drive(1'b0, '0, zr, zi, 1'b1, 1'b1);
        check("clr alone valid", 64'(max_valid), 0);

        // Reset mid-stream with full slots, held output and overflow.
        drive(1'b1, '0, zr, zi, 1'b0, 1'b1);
        drive(1'b0, 4'b0100, res4(0, 0, 12'h300, 0), zi, 1'b0, 1'b1);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b1);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b1);
        drive(1'b0, 4'b1111, res4(1, 2, 3, 4), ids4(1, 2, 3, 4), 1'b0, 1'b0);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b0);
        check("mid grant wraps to ch3", 64'(out_ch), 3);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b1);
        check("mid grant ch0", 64'(out_ch), 0);
        drive(1'b0, 4'b0010, res4(0, 7, 0, 0), zi, 1'b0, 1'b0);
        check("mid overflow1", 64'(overflow), 64'b0010);
        drive(1'b1, 4'b1111, res4(5, 6, 7, 8), ids4(5, 6, 7, 8), 1'b1, 1'b1);
        check("rst busy", 64'(busy), 0);
        check("rst out_valid", 64'(out_valid), 0);
        check("rst overflow", 64'(overflow), 0);
        check("rst max_valid", 64'(max_valid), 0);
        check("rst out_score", 64'(out_score), 0);
        check("rst out_id", 64'(out_id), 0);
        drive(1'b0, 4'b1111, res4(5, 6, 7, 8), ids4(5, 6, 7, 8), 1'b0, 1'b1);
        drive(1'b0, '0, zr, zi, 1'b0, 1'b1);
        check("rst ptr ch0 first", 64'(out_ch), 0);
        check("rst ptr score", 64'(out_score), 5);

        // Randomized traffic against the model.
        drive(1'b1, '0, zr, zi, 1'b0, 1'b1);
        rst = 1'b1;
        model_step();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < NC; c++) begin
                vld_in[c] = ($urandom_range(0, 9) < 4);
                sc = ($urandom_range(0, 1) == 1) ? SW'(12'h800 + $urandom_range(0, 7)) : SW'($urandom);
                res_in[c*SW +: SW] = sc;
                id_in[c*IW +: IW] = {16'($urandom), 32'($urandom)};
            end
            clr_max   = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            model_step();
            #1;
            check("rnd out_valid", 64'(out_valid), 64'(m_out_v));
            if (m_out_v) begin
                check("rnd out_ch", 64'(out_ch), 64'(m_out_ch));
                check("rnd out_score", 64'(out_score), 64'(m_out_s));
                check("rnd out_id", 64'(out_id), 64'(m_out_id));
            end
            check("rnd max_valid", 64'(max_valid), 64'(m_max_v));
            if (m_max_v) begin
                check("rnd max_score", 64'(max_score), 64'(m_max_s));
                check("rnd max_id", 64'(max_id), 64'(m_max_id));
            end
            check("rnd overflow", 64'(overflow), 64'(m_ovf));
            check("rnd busy", 64'(busy), 64'(model_busy()));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter SCORE_WIDTH, default 12, meaning score width in bits (biased, unsigned).
REQ-002 SHALL have parameter ID_WIDTH, default 48, meaning sequence ID width in bits.
REQ-003 SHALL have parameter CHANNELS, default 4, meaning number of result channels (2*MODULES of the score bank); CH_W = max(1,$clog2(CHANNELS)).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port vld_in, input, CHANNELS, meaning per-channel one-cycle result strobe.
REQ-007 SHALL have port res_in, input, CHANNELS*SCORE_WIDTH, meaning channel c score at bits [c*SCORE_WIDTH +: SCORE_WIDTH].
REQ-008 SHALL have port id_in, input, CHANNELS*ID_WIDTH, meaning channel c ID at bits [c*ID_WIDTH +: ID_WIDTH].
REQ-009 SHALL have port clr_max, input, 1, meaning new query; clear running max.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts out_* this cycle.
REQ-011 SHALL have port out_valid, output, 1, meaning out_score/out_id/out_ch hold a result.
REQ-012 SHALL have ports out_score (SCORE_WIDTH), out_id (ID_WIDTH), out_ch (CH_W), outputs, meaning serialized result, its ID, source channel.
REQ-013 SHALL have ports max_score (SCORE_WIDTH), max_id (ID_WIDTH), max_valid (1), outputs, meaning running maximum since last clr_max.
REQ-014 SHALL have port overflow, output, CHANNELS, meaning sticky per-channel dropped-result flag.
REQ-015 SHALL have port busy, output, 1, meaning any holding slot occupied or out_valid high.

Function
REQ-016 SHALL contain one holding slot (score, ID, full bit) per channel.
REQ-017 SHALL load slot c on vld_in[c] when slot c is empty or is granted in the same cycle (simultaneous grant+strobe: new data accepted).
REQ-018 SHALL, on vld_in[c] with slot c full and not granted, keep old contents, drop new data, set overflow[c]; overflow clears only on rst.
REQ-019 SHALL treat the output register as advanceable when out_valid=0 or out_ready=1.
REQ-020 SHALL, when advanceable and any slot full, grant the first full slot at or after rr_ptr (wrapping), move it to out_*, clear its full bit, set rr_ptr = grant+1 mod CHANNELS.
REQ-021 SHALL, when advanceable and no slot full, deassert out_valid; rr_ptr unchanged.
REQ-022 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL give latency: strobe at cycle N -> out_valid at N+2 earliest (slot at N+1, output at N+2); with out_ready tied high, sustains one result per cycle.
REQ-024 SHALL update max on strobed inputs (including dropped ones): candidate = largest res_in among vld_in bits, ties to lowest channel; replace when !max_valid or candidate > max_score (unsigned compare, strictly greater); set max_valid.
REQ-025 SHALL, on clr_max, clear max_valid; if strobes occur in the same cycle, max loads from this cycle's candidate (clear first, then update).
REQ-026 SHALL not let clr_max affect slots, output register or overflow.

Reset
REQ-027 SHALL on rst: out_valid=0, all slot full bits=0, rr_ptr=0, max_valid=0, overflow=0; out_score/out_id/out_ch/max_score/max_id=0.
REQ-028 SHALL let rst override all same-cycle events, including mid-stream; pending results discarded.

Structure
REQ-029 SHALL take SCORE_WIDTH, ID_WIDTH defaults and biased ZERO (2**(SCORE_WIDTH-1)) from the shared score-bank constants package/include.
REQ-030 SHALL isolate the round-robin grant logic in sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, grant index, any).

Verification
REQ-031 Single strobe ch2 score 0x805 ID 7, out_ready=1 -> out_valid two cycles later, out_ch=2, out_score=0x805, out_id=7, max_score=0x805, max_valid=1.
REQ-032 All 4 channels strobe same cycle (scores 0x801,0x810,0x810,0x802), out_ready=1 -> out_ch order 0,1,2,3 on consecutive cycles; max_score=0x810, max_id=ch1 ID.
REQ-033 out_ready=0, ch0 strobes twice (0x900, then 0x901) -> first held on out, second in slot; third strobe 0x902 -> overflow[0]=1, 0x902 never output, max_score=0x902.
REQ-034 Grant ch1 while ch1 strobes same cycle -> both old and new ch1 results output, overflow[1]=0.
REQ-035 clr_max with ch3 strobe 0x7F0 in same cycle after max 0xA00 -> max_score=0x7F0, max_valid=1.
REQ-036 rst asserted with slots full and out_valid=1 -> next cycle busy=0, out_valid=0, overflow=0, rr_ptr=0 (next simultaneous strobe granted from ch0).
